// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings, FSM states
// and default widths/latencies.
package md_pkg;

   localparam int MD_WIDTH       = 32;
   localparam int MD_MULT_CYCLES = 5;
   localparam int MD_DIV_CYCLES  = 10;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_e;

endpackage

// File: rtl/md_datapath.sv
// Combinational MD datapath: 2*WIDTH product and quotient/remainder from the latched
// operands. Signed divide works on magnitudes and restores signs afterwards.
module md_datapath
   import md_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  md_op_e             op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   hi_res,
   output logic [WIDTH-1:0]   lo_res,
   output logic               div_zero
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic               is_signed_div;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   b_safe;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;

   always_comb begin
      // Low 2*WIDTH bits of the sign-extended product equal the signed product.
      prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
      prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

      div_zero      = (b == '0);
      is_signed_div = (op == MD_DIV);
      a_neg         = is_signed_div & a[WIDTH-1];
      b_neg         = is_signed_div & b[WIDTH-1];
      a_mag         = a_neg ? -a : a;
      b_mag         = b_neg ? -b : b;
      b_safe        = div_zero ? ONE : b_mag;
      q_mag         = a_mag / b_safe;
      r_mag         = a_mag % b_safe;
      // Truncation toward zero; remainder follows the dividend's sign.
      quot          = (a_neg ^ b_neg) ? -q_mag : q_mag;
      rem           = a_neg ? -r_mag : r_mag;

      hi_res = rem;
      lo_res = quot;
      case (op)
         MD_MULT:  {hi_res, lo_res} = prod_s;
         MD_MULTU: {hi_res, lo_res} = prod_u;
         default:  {hi_res, lo_res} = {rem, quot};
      endcase
   end

endmodule

// File: rtl/md_scheduler.sv
// Multi-cycle mult/div scheduler: holds the MD datapath busy for a fixed latency,
// commits HI/LO on the final busy edge and stalls D on MD-class conflicts.
module md_scheduler
   import md_pkg::*;
#(
   parameter int WIDTH       = MD_WIDTH,
   parameter int MULT_CYCLES = MD_MULT_CYCLES,
   parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [WIDTH-1:0]   src_a,
   input  logic [WIDTH-1:0]   src_b,
   input  logic               hilo_we,
   input  logic               hilo_sel,
   input  logic [WIDTH-1:0]   hilo_wdata,
   input  logic               md_use_D,
   output logic               busy,
   output logic               stall,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo,
   output md_state_e          state_dbg
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW      = $clog2(MAX_CYC + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   md_state_e        state;
   md_state_e        next_state;
   logic [CW-1:0]    count;
   md_op_e           op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             accept;
   logic             commit;
   logic             mt_write;
   logic [WIDTH-1:0] hi_res;
   logic [WIDTH-1:0] lo_res;
   logic             div_zero;

   md_datapath #(.WIDTH(WIDTH)) u_datapath (
      .op       (op_q),
      .a        (a_q),
      .b        (b_q),
      .hi_res   (hi_res),
      .lo_res   (lo_res),
      .div_zero (div_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= ST_IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (start) next_state = ST_RUN;
         ST_RUN:  if (count == CNT_ONE) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == ST_RUN);
      accept    = (state == ST_IDLE) & start;
      commit    = (state == ST_RUN) & (count == CNT_ONE);
      // A same-cycle start takes priority over mthi/mtlo.
      mt_write  = (state == ST_IDLE) & ~start & hilo_we;
      stall     = md_use_D & (busy | start);
      state_dbg = state;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         op_q  <= MD_MULT;
         a_q   <= '0;
         b_q   <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         if (accept) begin
            count <= op[1] ? DIV_LOAD : MULT_LOAD;
            op_q  <= md_op_e'(op);
            a_q   <= src_a;
            b_q   <= src_b;
         end else if (busy) begin
            count <= count - CNT_ONE;
         end

         if (commit) begin
            // Divide by zero runs the full latency but leaves HI/LO untouched.
            if (!(op_q[1] & div_zero)) begin
               hi <= hi_res;
               lo <= lo_res;
            end
         end else if (mt_write) begin
            if (hilo_sel) hi <= hilo_wdata;
            else          lo <= hilo_wdata;
         end
      end
   end

endmodule

// File: tb/tb_md_scheduler.sv
// Self-checking bench for md_scheduler: directed scenarios plus random mult/div
// traffic, scored against a plain-arithmetic reference model.
module tb_md_scheduler;
   import md_pkg::*;

   // Handshake: start/hilo_we are single-cycle strobes driven only while busy==0;
   // a strobe is consumed at the next rising edge, results appear when busy drops.

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        hilo_we;
   logic        hilo_sel;
   logic [31:0] hilo_wdata;
   logic        md_use_D;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   md_state_e   state_dbg;

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q[$];
   int          len_q[$];
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   int          run_len;
   logic        prev_busy;

   md_scheduler dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .op         (op),
      .src_a      (src_a),
      .src_b      (src_b),
      .hilo_we    (hilo_we),
      .hilo_sel   (hilo_sel),
      .hilo_wdata (hilo_wdata),
      .md_use_D   (md_use_D),
      .busy       (busy),
      .stall      (stall),
      .hi         (hi),
      .lo         (lo),
      .state_dbg  (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: results straight from the arithmetic definitions.
   function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
      longint      sa;
      longint      sb;
      longint      p;
      longint      q;
      longint      r;
      logic [63:0] qv;
      logic [63:0] rv;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = cur;
      case (o)
         2'b00: begin p = sa * sb; res = p; end
         2'b01: res = 64'(a) * 64'(b);
         2'b10: if (b != 0) begin
            q = sa / sb; r = sa % sb;
            qv = q; rv = r;
            res = {rv[31:0], qv[31:0]};
         end
         default: if (b != 0) res = {a % b, a / b};
      endcase
      return res;
   endfunction

   // Driver tasks: each starts and ends just after a rising edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic we, input logic [31:0] wd);
      int          n;
      logic [63:0] e;
      n = o[1] ? MD_DIV_CYCLES : MD_MULT_CYCLES;
      e = ref_op(o, a, b, {m_hi, m_lo});
      exp_q.push_back(e);
      len_q.push_back(n);
      m_hi = e[63:32];
      m_lo = e[31:0];
      start = 1'b1; op = o; src_a = a; src_b = b; md_use_D = use_d;
      hilo_we = we; hilo_sel = 1'b0; hilo_wdata = wd;
      @(negedge clk);
      check("stall_on_start", stall, use_d);
      @(posedge clk); #1;
      start = 1'b0; hilo_we = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("busy_run", busy, 1'b1);
         check("stall_run", stall, use_d);
      end
      @(posedge clk); #1;
      check("busy_after_commit", busy, 1'b0);
      check("stall_after_commit", stall, 1'b0);
      check("hilo_after_commit", {hi, lo}, e);
      md_use_D = 1'b0;
   endtask

   task automatic mt(input logic sel, input logic [31:0] wd);
      hilo_we = 1'b1; hilo_sel = sel; hilo_wdata = wd;
      @(posedge clk); #1;
      hilo_we = 1'b0;
      if (sel) m_hi = wd;
      else     m_lo = wd;
      check("mthi_mtlo", {hi, lo}, {m_hi, m_lo});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Scoreboard monitor: compares on each busy->idle transition.
   always @(negedge clk) begin
      if (!reset) begin
         exp_q.delete();
         len_q.delete();
         run_len   = 0;
         prev_busy = 1'b0;
      end else begin
         if (busy && (start || hilo_we)) check("no_strobe_while_busy", 1'b1, 1'b0);
         if (busy) begin
            run_len++;
         end else if (prev_busy) begin
            if (exp_q.size() == 0) begin
               check("unexpected_commit", 1'b1, 1'b0);
            end else begin
               check("sb_hilo", {hi, lo}, exp_q.pop_front());
               check("sb_busy_len", 64'(run_len), 64'(len_q.pop_front()));
            end
            run_len = 0;
         end
         prev_busy = busy;
      end
   end

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      hilo_we = 1'b0; hilo_sel = 1'b0; hilo_wdata = '0; md_use_D = 1'b0;
      m_hi = '0; m_lo = '0;
      #1;
      check("reset_busy", busy, 1'b0);
      check("reset_hilo", {hi, lo}, 64'h0);
      check("reset_state", state_dbg, ST_IDLE);
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;

      // Abort mid-divide: clears at once, never commits afterwards.
      mt(1'b1, 32'hDEAD);
      mt(1'b0, 32'hBEEF);
      start = 1'b1; op = MD_DIV; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("abort_busy_pre", busy, 1'b1);
      end
      #2 reset = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_hilo", {hi, lo}, 64'h0);
      m_hi = '0; m_lo = '0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check("abort_no_busy", busy, 1'b0);
      end
      @(posedge clk); #1;
      check("abort_no_commit", {hi, lo}, 64'h0);

      // Directed arithmetic corners.
      issue(MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, '0);
      check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
      issue(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, '0);
      check("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
      issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, '0);
      check("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
      issue(MD_DIVU, 32'd7, 32'd0, 1'b0, 1'b0, '0);
      check("divu_zero_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

      // Stall across the whole mult with mflo waiting in D.
      issue(MD_MULT, 32'd6, 32'd7, 1'b1, 1'b0, '0);
      check("mflo_new_lo", lo, 32'd42);

      // start beats a same-cycle mtlo; a lone mtlo writes.
      mt(1'b0, 32'hAAAA);
      issue(MD_MULT, 32'd3, 32'd5, 1'b0, 1'b1, 32'h1234);
      check("start_beats_mtlo", lo, 32'd15);
      mt(1'b0, 32'h1234);
      check("mtlo_const", lo, 32'h1234);

      // Overflow divide, then back-to-back start.
      issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, '0);
      check("div_ovf_const", {hi, lo}, 64'h00000000_80000000);
      issue(MD_MULTU, 32'h10000, 32'h10000, 1'b1, 1'b0, '0);
      check("b2b_const", {hi, lo}, 64'h00000001_00000000);

      // Random traffic.
      for (int k = 0; k < 40; k++) begin
         ro = 2'($urandom_range(0, 3));
         ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 5))
            0:       rb = 32'd0;
            1:       rb = 32'd1;
            2:       rb = 32'hFFFFFFFF;
            3:       rb = 32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), $urandom);
         issue(ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
         idle($urandom_range(0, 2));
      end

      idle(4);
      check("sb_drained", 64'(exp_q.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
